// File: rtl/mod_pkg.sv
// Shared types and defaults for the modulus dispatch front end.
package mod_pkg;

   localparam int MOD_WIDTH_DEFAULT = 8;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ISSUE     = 3'd1,
      ST_WAIT_BUSY = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_ERR       = 3'd4
   } mod_dispatch_state_t;

   typedef struct packed {
      logic [MOD_WIDTH_DEFAULT-1:0] value;
      logic [MOD_WIDTH_DEFAULT-1:0] modulus;
   } mod_job_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous job FIFO with registered ready (not full) and occupancy count.
module sync_fifo #(
   parameter int DW    = 16,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = $clog2(DEPTH) + 1
) (
   input  logic          clk_in,
   input  logic          rst_in,
   input  logic          push,
   input  logic          pop,
   input  logic [DW-1:0] wr_data,
   output logic [DW-1:0] rd_data,
   output logic [CW-1:0] count,
   output logic [CW-1:0] count_next,
   output logic          ready,
   output logic          empty
);

   logic [DW-1:0] mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;
   logic [CW-1:0] count_s;
   logic          ready_r;
   logic          push_ok_s;
   logic          pop_ok_s;

   assign push_ok_s  = push && ready_r;
   assign pop_ok_s   = pop && (count_r != {CW{1'b0}});
   assign rd_data    = mem_r[rd_ptr_r];
   assign count      = count_r;
   assign count_next = count_s;
   assign ready      = ready_r;
   assign empty      = (count_r == {CW{1'b0}});

   // occupancy after this edge; simultaneous push and pop cancel out
   always_comb begin
      count_s = count_r;
      if (push_ok_s && !pop_ok_s) begin
         count_s = count_r + CW'(1);
      end else if (!push_ok_s && pop_ok_s) begin
         count_s = count_r - CW'(1);
      end else begin
         count_s = count_r;
      end
   end

   // storage array, written only on an accepted push
   always_ff @(posedge clk_in) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

   // pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
         ready_r  <= 1'b0;
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         count_r <= count_s;
         ready_r <= (count_s != CW'(DEPTH));
      end
   end

endmodule

// File: rtl/mod_dispatch.sv
// Dispatcher between a job stream and the modulus responder.
// Optional watchdog compiled in with MOD_DISPATCH_TIMEOUT_EN.
module mod_dispatch
   import mod_pkg::*;
#(
   parameter int WIDTH   = MOD_WIDTH_DEFAULT,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic                     job_valid_in,
   output logic                     job_ready_out,
   input  logic [WIDTH-1:0]         job_value_in,
   input  logic [WIDTH-1:0]         job_modulus_in,
   output logic                     mod_ready_out,
   output logic [WIDTH-1:0]         mod_value_out,
   output logic [WIDTH-1:0]         mod_modulus_out,
   input  logic                     mod_busy_in,
   input  logic                     mod_valid_in,
   input  logic [WIDTH-1:0]         mod_value_in,
   output logic                     res_valid_out,
   input  logic                     res_ready_in,
   output logic [WIDTH-1:0]         res_value_out,
   output logic                     res_err_out,
   output logic                     busy_out,
   output logic [$clog2(DEPTH):0]   count_out
);

   localparam int CW = $clog2(DEPTH) + 1;

   mod_dispatch_state_t state_r, state_s;
   logic [2*WIDTH-1:0]  head_s;
   logic [WIDTH-1:0]    head_value_s, head_mod_s;
   logic [CW-1:0]       fifo_count_s, fifo_count_next_s;
   logic                fifo_empty_s, fifo_ready_s;
   logic                pop_s, timeout_s;
   logic [WIDTH-1:0]    op_value_r, op_mod_r;
   logic                mod_ready_r, busy_r;
   logic                res_valid_r, res_valid_s;
   logic [WIDTH-1:0]    res_value_r, res_value_s;
   logic                res_err_r, res_err_s;

   sync_fifo #(.DW(2*WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk_in     (clk_in),
      .rst_in     (rst_in),
      .push       (job_valid_in),
      .pop        (pop_s),
      .wr_data    ({job_value_in, job_modulus_in}),
      .rd_data    (head_s),
      .count      (fifo_count_s),
      .count_next (fifo_count_next_s),
      .ready      (fifo_ready_s),
      .empty      (fifo_empty_s)
   );

   assign head_value_s = head_s[2*WIDTH-1:WIDTH];
   assign head_mod_s   = head_s[WIDTH-1:0];

`ifdef MOD_DISPATCH_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT) + 1;
   logic [WD_W-1:0] wd_r;

   // watchdog: cycles spent waiting on the responder
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         wd_r <= {WD_W{1'b0}};
      end else if (state_r == ST_WAIT_BUSY || state_r == ST_WAIT_DONE) begin
         wd_r <= wd_r + WD_W'(1);
      end else begin
         wd_r <= {WD_W{1'b0}};
      end
   end

   assign timeout_s = (wd_r == WD_W'(TIMEOUT - 1));
`else
   logic unused_timeout_s;
   assign unused_timeout_s = ^TIMEOUT;
   assign timeout_s        = 1'b0;
`endif

   // next state, pop decision and result-register update
   always_comb begin
      state_s     = state_r;
      pop_s       = 1'b0;
      res_valid_s = res_valid_r;
      res_value_s = res_value_r;
      res_err_s   = res_err_r;
      if (res_valid_r && res_ready_in) begin
         res_valid_s = 1'b0;
         res_value_s = {WIDTH{1'b0}};
         res_err_s   = 1'b0;
      end else begin
         res_valid_s = res_valid_r;
      end
      case (state_r)
         ST_IDLE: begin
            if (!fifo_empty_s && !res_valid_r && !mod_busy_in) begin
               pop_s = 1'b1;
               if (head_mod_s == {WIDTH{1'b0}}) begin
                  state_s = ST_ERR;
               end else begin
                  state_s = ST_ISSUE;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ISSUE: state_s = ST_WAIT_BUSY;
         ST_WAIT_BUSY, ST_WAIT_DONE: begin
            // a done pulse wins over a coincident timeout or busy edge
            if (mod_valid_in) begin
               res_valid_s = 1'b1;
               res_value_s = mod_value_in;
               res_err_s   = 1'b0;
               state_s     = ST_IDLE;
            end else if (timeout_s) begin
               state_s = ST_ERR;
            end else if (mod_busy_in) begin
               state_s = ST_WAIT_DONE;
            end else begin
               state_s = state_r;
            end
         end
         ST_ERR: begin
            res_valid_s = 1'b1;
            res_value_s = {WIDTH{1'b0}};
            res_err_s   = 1'b1;
            state_s     = ST_IDLE;
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // state, operand, request and result registers
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_r     <= ST_IDLE;
         op_value_r  <= {WIDTH{1'b0}};
         op_mod_r    <= {WIDTH{1'b0}};
         mod_ready_r <= 1'b0;
         res_valid_r <= 1'b0;
         res_value_r <= {WIDTH{1'b0}};
         res_err_r   <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         mod_ready_r <= (state_s == ST_ISSUE);
         if (pop_s) begin
            op_value_r <= head_value_s;
            op_mod_r   <= head_mod_s;
         end
         res_valid_r <= res_valid_s;
         res_value_r <= res_value_s;
         res_err_r   <= res_err_s;
         busy_r      <= (state_s != ST_IDLE) || (fifo_count_next_s != {CW{1'b0}}) || res_valid_s;
      end
   end

   assign job_ready_out   = fifo_ready_s;
   assign mod_ready_out   = mod_ready_r;
   assign mod_value_out   = op_value_r;
   assign mod_modulus_out = op_mod_r;
   assign res_valid_out   = res_valid_r;
   assign res_value_out   = res_value_r;
   assign res_err_out     = res_err_r;
   assign busy_out        = busy_r;
   assign count_out       = fifo_count_s;

endmodule

// File: tb/tb_mod_dispatch.sv
// Self-checking bench for mod_dispatch: responder model, job/result scoreboard, directed and random jobs.
`timescale 1ns/1ps
module tb_mod_dispatch;
   import mod_pkg::*;

   localparam int WIDTH   = 8;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 64;

   logic clk_in = 1'b0;
   logic rst_in = 1'b1;
   logic job_valid_in = 1'b0, job_ready_out;
   logic [WIDTH-1:0] job_value_in = '0, job_modulus_in = '0;
   logic mod_ready_out;
   logic [WIDTH-1:0] mod_value_out, mod_modulus_out;
   logic mod_busy_in = 1'b0, mod_valid_in = 1'b0;
   logic [WIDTH-1:0] mod_value_in = '0;
   logic res_valid_out, res_ready_in = 1'b0, res_err_out, busy_out;
   logic [WIDTH-1:0] res_value_out;
   logic [$clog2(DEPTH):0] count_out;

   always #5 clk_in = ~clk_in;

   mod_dispatch #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk_in(clk_in), .rst_in(rst_in),
      .job_valid_in(job_valid_in), .job_ready_out(job_ready_out),
      .job_value_in(job_value_in), .job_modulus_in(job_modulus_in),
      .mod_ready_out(mod_ready_out), .mod_value_out(mod_value_out),
      .mod_modulus_out(mod_modulus_out), .mod_busy_in(mod_busy_in),
      .mod_valid_in(mod_valid_in), .mod_value_in(mod_value_in),
      .res_valid_out(res_valid_out), .res_ready_in(res_ready_in),
      .res_value_out(res_value_out), .res_err_out(res_err_out),
      .busy_out(busy_out), .count_out(count_out)
   );

   int tests = 0, fails = 0;
   int pulses = 0, results = 0, cyc = 0;
   int rsp_cnt = 0, rsp_lat = 4;
   bit rsp_en = 1'b1, rand_lat = 1'b0, rand_ready = 1'b0, tmo_mode = 1'b0, prev_rdy = 1'b0;
   logic [WIDTH-1:0] rsp_v = '0, rsp_m = '0;
   mod_job_t job_q[$];

   typedef struct {
      logic [WIDTH-1:0] v;
      logic [WIDTH-1:0] m;
      int               lat;
      logic [WIDTH-1:0] rem;
      logic             err;
      int               npulse;
   } vec_t;
   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk_in) cyc <= cyc + 1;

   // responder model: busy the cycle after a request, done pulse after a latency
   initial forever begin
      @(posedge clk_in); #2;
      if (rst_in) begin
         mod_busy_in = 1'b0; mod_valid_in = 1'b0; rsp_cnt = 0;
      end else if (rsp_en) begin
         mod_valid_in = 1'b0;
         if (rsp_cnt > 0) begin
            chk("operand_value_stable", {24'd0, mod_value_out}, {24'd0, rsp_v});
            chk("operand_mod_stable", {24'd0, mod_modulus_out}, {24'd0, rsp_m});
            rsp_cnt--;
            if (rsp_cnt == 0) begin
               mod_busy_in  = 1'b0;
               mod_valid_in = 1'b1;
               mod_value_in = (rsp_m == 0) ? '0 : rsp_v % rsp_m;
            end
         end else if (mod_ready_out) begin
            rsp_v = mod_value_out; rsp_m = mod_modulus_out;
            chk("no_issue_zero_mod", {31'd0, rsp_m != 0}, 32'd1);
            mod_busy_in = 1'b1;
            rsp_cnt = rand_lat ? int'($urandom_range(1, 8)) : rsp_lat;
         end
      end
   end

   // scoreboard: jobs in arrival order, results compared against the arithmetic rule
   initial forever begin
      @(posedge clk_in); #3;
      if (rst_in) begin
         job_q.delete();
         prev_rdy = 1'b0;
      end else begin
         if (mod_ready_out) begin
            pulses++;
            chk("req_pulse_one_cycle", {31'd0, prev_rdy}, 32'd0);
         end
         prev_rdy = mod_ready_out;
         if (job_valid_in && job_ready_out) job_q.push_back('{job_value_in, job_modulus_in});
         if (res_valid_out && res_ready_in) begin
            results++;
            if (job_q.size() == 0) begin
               chk("result_without_job", 32'd1, 32'd0);
            end else begin
               mod_job_t j;
               logic [WIDTH-1:0] er;
               logic ee;
               j = job_q.pop_front();
               ee = tmo_mode || (j.modulus == 0);
               er = ee ? '0 : j.value % j.modulus;
               chk("sb_value", {24'd0, res_value_out}, {24'd0, er});
               chk("sb_err", {31'd0, res_err_out}, {31'd0, ee});
            end
         end
      end
   end

   // random downstream backpressure when enabled
   initial forever begin
      @(posedge clk_in); #1;
      if (rand_ready) res_ready_in = 1'($urandom_range(0, 1));
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clk_in); #1;
   endtask

   task automatic push_job(input logic [WIDTH-1:0] v, input logic [WIDTH-1:0] m);
      int n = 0;
      job_valid_in = 1'b1; job_value_in = v; job_modulus_in = m;
      while (!job_ready_out && n < 400) begin step(); n++; end
      if (n >= 400) chk("push_ready_timeout", {31'd0, job_ready_out}, 32'd1);
      step();
      job_valid_in = 1'b0;
   endtask

   task automatic wait_result(input int lim);
      int n = 0;
      while (!res_valid_out && n < lim) begin step(); n++; end
      if (n >= lim) chk("result_wait_timeout", {31'd0, res_valid_out}, 32'd1);
   endtask

   task automatic accept();
      res_ready_in = 1'b1; step(); res_ready_in = 1'b0;
   endtask

   task automatic wait_idle(input int lim);
      int n = 0;
      while (busy_out && n < lim) begin step(); n++; end
      chk("drain_idle", {31'd0, busy_out}, 32'd0);
   endtask

   initial begin
      int p0, r0, t0;
      vecs[0] = '{8'd17,  8'd5,   16, 8'd2,  1'b0, 1};
      vecs[1] = '{8'd9,   8'd0,   4,  8'd0,  1'b1, 0};
      vecs[2] = '{8'd9,   8'd4,   3,  8'd1,  1'b0, 1};
      vecs[3] = '{8'd200, 8'd7,   1,  8'd4,  1'b0, 1};
      vecs[4] = '{8'd255, 8'd255, 2,  8'd0,  1'b0, 1};
      vecs[5] = '{8'd0,   8'd3,   1,  8'd0,  1'b0, 1};
      vecs[6] = '{8'd100, 8'd1,   5,  8'd0,  1'b0, 1};
      vecs[7] = '{8'd13,  8'd200, 4,  8'd13, 1'b0, 1};

      repeat (3) @(posedge clk_in); #1;
      chk("rst_job_ready", {31'd0, job_ready_out}, 32'd0);
      chk("rst_res_valid", {31'd0, res_valid_out}, 32'd0);
      chk("rst_mod_ready", {31'd0, mod_ready_out}, 32'd0);
      chk("rst_count", {28'd0, count_out}, 32'd0);
      chk("rst_busy", {31'd0, busy_out}, 32'd0);
      chk("rst_res_value", {24'd0, res_value_out}, 32'd0);
      rst_in = 1'b0;
      step();
      chk("job_ready_after_reset", {31'd0, job_ready_out}, 32'd1);

      // table-driven single jobs
      for (int i = 0; i < 8; i++) begin
         rsp_lat = vecs[i].lat;
         p0 = pulses;
         push_job(vecs[i].v, vecs[i].m);
         wait_result(200);
         chk("vec_value", {24'd0, res_value_out}, {24'd0, vecs[i].rem});
         chk("vec_err", {31'd0, res_err_out}, {31'd0, vecs[i].err});
         chk("vec_req_pulses", pulses - p0, vecs[i].npulse);
         accept();
         chk("vec_busy_after_accept", {31'd0, busy_out}, 32'd0);
      end

      // backpressure: result held, no new request while the register is full
      rsp_lat = 3;
      push_job(8'd77, 8'd10);
      wait_result(100);
      p0 = pulses;
      push_job(8'd50, 8'd6);
      for (int i = 0; i < 30; i++) begin
         step();
         chk("bp_valid_held", {31'd0, res_valid_out}, 32'd1);
         chk("bp_value_held", {24'd0, res_value_out}, 32'd7);
      end
      chk("bp_no_request", pulses - p0, 0);
      chk("bp_count", {28'd0, count_out}, 32'd1);
      accept();
      wait_result(100);
      chk("bp_second_value", {24'd0, res_value_out}, 32'd2);
      accept();

      // full FIFO: one job in flight plus four buffered, the next is held off
      rsp_lat = 2;
      r0 = results;
      push_job(8'd10, 8'd3); push_job(8'd11, 8'd3); push_job(8'd12, 8'd5);
      push_job(8'd13, 8'd4); push_job(8'd14, 8'd6);
      repeat (10) step();
      chk("full_count", {28'd0, count_out}, 32'd4);
      chk("full_ready_low", {31'd0, job_ready_out}, 32'd0);
      job_valid_in = 1'b1; job_value_in = 8'd15; job_modulus_in = 8'd4;
      repeat (8) step();
      chk("full_held_count", {28'd0, count_out}, 32'd4);
      chk("full_held_queue", job_q.size(), 5);
      res_ready_in = 1'b1;
      begin
         int n = 0;
         while (!job_ready_out && n < 200) begin step(); n++; end
         chk("full_ready_returns", {31'd0, job_ready_out}, 32'd1);
      end
      step();
      job_valid_in = 1'b0;
      wait_idle(500);
      res_ready_in = 1'b0;
      chk("full_all_results", results - r0, 6);

      // zero modulus followed by a normal job
      res_ready_in = 1'b1;
      p0 = pulses; r0 = results;
      push_job(8'd9, 8'd0); push_job(8'd9, 8'd4);
      wait_idle(200);
      res_ready_in = 1'b0;
      chk("zero_pulses", pulses - p0, 1);
      chk("zero_results", results - r0, 2);

      // asynchronous reset while waiting for the done pulse
      rsp_lat = 20;
      push_job(8'd100, 8'd7); push_job(8'd30, 8'd4); push_job(8'd31, 8'd4);
      repeat (8) step();
      chk("pre_reset_busy", {31'd0, mod_busy_in}, 32'd1);
      @(posedge clk_in); #5;
      rst_in = 1'b1;
      #1;
      chk("arst_res_valid", {31'd0, res_valid_out}, 32'd0);
      chk("arst_mod_value", {24'd0, mod_value_out}, 32'd0);
      chk("arst_mod_modulus", {24'd0, mod_modulus_out}, 32'd0);
      chk("arst_count", {28'd0, count_out}, 32'd0);
      chk("arst_busy", {31'd0, busy_out}, 32'd0);
      chk("arst_job_ready", {31'd0, job_ready_out}, 32'd0);
      step(); step();
      rst_in = 1'b0;
      step();
      rsp_lat = 4; r0 = results;
      push_job(8'd100, 8'd7);
      wait_result(100);
      chk("post_reset_value", {24'd0, res_value_out}, 32'd2);
      accept();
      chk("post_reset_results", results - r0, 1);

`ifdef MOD_DISPATCH_TIMEOUT_EN
      // responder never answers: watchdog produces an error result
      rsp_en = 1'b0; tmo_mode = 1'b1;
      p0 = pulses;
      push_job(8'd50, 8'd7);
      t0 = cyc;
      wait_result(TIMEOUT + 40);
      chk("tmo_not_early", {31'd0, (cyc - t0) >= TIMEOUT}, 32'd1);
      chk("tmo_err", {31'd0, res_err_out}, 32'd1);
      chk("tmo_value", {24'd0, res_value_out}, 32'd0);
      chk("tmo_one_request", pulses - p0, 1);
      accept();
      tmo_mode = 1'b0;
      mod_valid_in = 1'b1; mod_value_in = 8'h55;
      step();
      mod_valid_in = 1'b0;
      repeat (3) step();
      chk("late_done_ignored", {31'd0, res_valid_out}, 32'd0);
      chk("late_done_idle", {31'd0, busy_out}, 32'd0);
      rsp_en = 1'b1;
`endif

      // random jobs with random latency and backpressure
      rand_lat = 1'b1; rand_ready = 1'b1;
      r0 = results;
      for (int i = 0; i < 40; i++) begin
         logic [WIDTH-1:0] v, m;
         v = WIDTH'($urandom_range(0, 255));
         m = ($urandom_range(0, 3) == 0) ? '0 : WIDTH'($urandom_range(1, 255));
         push_job(v, m);
         if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 6)) step();
      end
      wait_idle(4000);
      rand_ready = 1'b0;
      step();
      res_ready_in = 1'b0;
      chk("rand_results", results - r0, 40);
      chk("rand_queue_empty", job_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
